icache_flush_seq: RTL
=====================

# icache_flush_seq

Flush and invalidate sequencer for the dual-issue instruction cache. It sits directly upstream of the icache lookup stage and owns every write that clears a tag-RAM valid bit. It serialises two kinds of request: full-cache flushes, which drain in-flight lookups and then walk every line index, and single-line invalidates. While a flush is in progress it stalls the lookup stage, and it reports completion with a one-cycle pulse.

## Interface
Parameters:
- NUM_LINES, 256, number of cache lines; must be a power of two and ≥ 2.
- INDEX_W, $clog2(NUM_LINES), width of a line index.
- FLUSH_ON_RESET, 1, when 1 a full flush starts automatically on reset release.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- flush_req_i  input  1  full-flush request; the requester holds it high until flush_ack_o.
- flush_ack_o  output  1  flush accepted this cycle (combinational).
- inv_valid_i  input  1  single-line invalidate request.
- inv_index_i  input  INDEX_W  line index to invalidate.
- inv_ready_o  output  1  invalidate can be accepted this cycle (combinational).
- lookup_busy_i  input  1  the lookup stage has an outstanding request.
- lookup_stall_o  output  1  blocks new lookups; registered.
- tag_wr_o  output  1  tag-RAM write strobe; the written valid bit is always 0.
- tag_wr_index_o  output  INDEX_W  tag-RAM write index.
- busy_o  output  1  high in any state other than IDLE.
- flush_done_o  output  1  one-cycle pulse when a flush completes.

## Operation
- The state machine has four states: IDLE, DRAIN, WALK, DONE.
- IDLE:
  - flush_ack_o = flush_req_i; when it is high, go to DRAIN.
  - inv_ready_o = ~flush_req_i.
  - When inv_valid_i & inv_ready_o, latch inv_index_i and stay in IDLE.
- DRAIN:
  - Hold while lookup_busy_i = 1.
  - When lookup_busy_i = 0, clear the line counter and go to WALK.
- WALK:
  - Assert tag_wr_o every cycle with tag_wr_index_o = counter; the counter increments each cycle.
  - When counter = NUM_LINES-1, go to DONE. The counter wraps to 0 and is not reused.
- DONE: flush_done_o = 1; go to IDLE.
- Outside IDLE, flush_ack_o = 0 and inv_ready_o = 0. Requests are not queued; the requester keeps them asserted.
- When flush_req_i and inv_valid_i are both high in IDLE, the flush wins; the invalidate is not accepted.
- lookup_stall_o = (state ≠ IDLE), registered from the next state.
- tag_wr_o is driven by exactly one source at a time: WALK, or a latched single invalidate. The two never overlap, because the cycle after any acceptance is either IDLE or DRAIN.

## Timing
- Reset values:
  - state = DRAIN if FLUSH_ON_RESET, otherwise IDLE.
  - counter = 0.
  - lookup_stall_o = FLUSH_ON_RESET; busy_o = FLUSH_ON_RESET.
  - tag_wr_o = 0, tag_wr_index_o = 0, flush_done_o = 0.
- Flush accepted at cycle T with lookup_busy_i = 0:
  - DRAIN and stall at T+1.
  - Writes to indices 0..NUM_LINES-1 at T+2 .. T+NUM_LINES+1.
  - flush_done_o at T+NUM_LINES+2.
  - lookup_stall_o low at T+NUM_LINES+3.
  - Each extra busy cycle in DRAIN adds exactly one cycle to this sequence.
- Single invalidate accepted at T: tag_wr_o = 1 with the latched index at T+1 only.
- Asserting reset mid-WALK aborts immediately. No flush_done_o is emitted. If FLUSH_ON_RESET = 1, a fresh flush restarts from index 0 after release.
- The counter is INDEX_W bits wide. The terminal test compares against NUM_LINES-1 and does not depend on overflow.

## Structure
- Shared package icache_pkg holds:
  - the state enum icache_flush_state_e (IDLE, DRAIN, WALK, DONE);
  - the localparam ICACHE_NUM_LINES used by both the lookup stage and this block.
- No sub-module: the counter and the state machine live in a single file.

## Test plan
- FLUSH_ON_RESET = 1, NUM_LINES = 8, lookup_busy_i = 0, release reset at cycle 0:
  - writes to indices 0..7 at cycles 1..8;
  - flush_done_o at 9;
  - lookup_stall_o low at 10.
- From IDLE, flush_req_i at T with lookup_busy_i high until T+4:
  - flush_ack_o high at T only;
  - tag_wr_o first high at T+5;
  - no writes during DRAIN.
- inv_valid_i with inv_index_i = 5 in IDLE at T: exactly one write, index 5, at T+1.
- flush_req_i and inv_valid_i both high in IDLE:
  - flush_ack_o = 1, inv_ready_o = 0;
  - no write to the invalidate index before the walk.
- inv_valid_i held high during WALK: inv_ready_o stays 0; the invalidate is accepted only in the first IDLE cycle after DONE.
- Assert rst_ni low mid-WALK at index 3, with FLUSH_ON_RESET = 0:
  - all outputs return to reset values asynchronously;
  - no flush_done_o;
  - the next flush walks from index 0.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared icache definitions: the line count used by the lookup stage and the
// flush sequencer, and the flush sequencer state encoding.
package icache_pkg;

  localparam int unsigned ICACHE_NUM_LINES = 256;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StWalk,
    StDone
  } icache_flush_state_e;

endpackage

// File: rtl/icache_flush_seq.sv
// Icache flush/invalidate sequencer: serialises full-cache flushes and
// single-line invalidates onto the tag-RAM valid-bit clear port.
module icache_flush_seq
  import icache_pkg::*;
#(
  parameter int unsigned NUM_LINES      = ICACHE_NUM_LINES,
  parameter int unsigned INDEX_W        = $clog2(NUM_LINES),
  parameter bit          FLUSH_ON_RESET = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_req_i,
  output logic               flush_ack_o,
  input  logic               inv_valid_i,
  input  logic [INDEX_W-1:0] inv_index_i,
  output logic               inv_ready_o,
  input  logic               lookup_busy_i,
  output logic               lookup_stall_o,
  output logic               tag_wr_o,
  output logic [INDEX_W-1:0] tag_wr_index_o,
  output logic               busy_o,
  output logic               flush_done_o
);

  localparam icache_flush_state_e ResetState = FLUSH_ON_RESET ? StDrain : StIdle;
  localparam logic [INDEX_W-1:0]  LastIndex  = INDEX_W'(NUM_LINES - 1);

  icache_flush_state_e state_q, state_d;
  logic [INDEX_W-1:0]  cnt_q, cnt_d;
  logic [INDEX_W-1:0]  inv_idx_q;
  logic                inv_pend_q;
  logic                inv_accept;
  logic                stall_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flush_ack_o = 1'b0;
    inv_ready_o = 1'b0;
    inv_accept  = 1'b0;
    case (state_q)
      StIdle: begin
        flush_ack_o = flush_req_i;
        inv_ready_o = ~flush_req_i;
        // A flush always beats a simultaneous invalidate.
        if (flush_req_i) begin
          state_d = StDrain;
        end else if (inv_valid_i) begin
          inv_accept = 1'b1;
        end
      end
      StDrain: begin
        if (!lookup_busy_i) begin
          cnt_d   = '0;
          state_d = StWalk;
        end
      end
      StWalk: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIndex) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ResetState;
      cnt_q      <= '0;
      inv_idx_q  <= '0;
      inv_pend_q <= 1'b0;
      stall_q    <= FLUSH_ON_RESET;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inv_pend_q <= inv_accept;
      stall_q    <= (state_d != StIdle);
      if (inv_accept) begin
        inv_idx_q <= inv_index_i;
      end
    end
  end

  // A pending invalidate can only coexist with IDLE or DRAIN, never WALK.
  assign tag_wr_o       = (state_q == StWalk) | inv_pend_q;
  assign tag_wr_index_o = inv_pend_q ? inv_idx_q : cnt_q;
  assign busy_o         = (state_q != StIdle);
  assign flush_done_o   = (state_q == StDone);
  assign lookup_stall_o = stall_q;

endmodule
